// File: rtl/pavana_xbar_pkg.sv
// Shared constants and helpers for the crossbar slave-side TID allocator.
package pavana_xbar_pkg;

  // Default tag width; the pool holds 2**TAG_WIDTH tags.
  localparam int TAG_WIDTH_DEF = 2;

  // Crossbar command encoding.
  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  // Number of tags in a pool addressed by a tag of the given width.
  function automatic int ntags(input int tag_width);
    return 1 << tag_width;
  endfunction

endpackage

// File: rtl/pavana_prio_enc.sv
// Lowest-zero-bit finder: returns the index of the lowest clear bit and
// whether any clear bit exists at all.
module pavana_prio_enc #(
  parameter int W  = 4,
  parameter int IW = 2
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // Scan from the top down so the last (lowest) clear bit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!vec_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pavana_tid_alloc.sv
// Per-slave read TID allocator and issue gate. Hands the lowest free tag to
// each accepted read, stalls reads when no tag is free or the response
// sequencer cannot take another tag, and recycles tags on slave responses.
module pavana_tid_alloc
  import pavana_xbar_pkg::*;
#(
  parameter int TAG_WIDTH       = TAG_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 m_req_i,
  input  logic                 m_cmd_i,
  output logic                 m_ack_o,
  output logic                 s_req_o,
  input  logic                 s_ack_i,
  output logic [TAG_WIDTH-1:0] s_reqtid_o,
  input  logic                 s_resp_i,
  input  logic [TAG_WIDTH-1:0] s_resptid_i,
  input  logic                 seq_full_i,
  output logic                 tag_wr_o,
  output logic [TAG_WIDTH:0]   outstanding_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int                 NTAGS   = ntags(TAG_WIDTH);
  localparam logic [TAG_WIDTH:0] MAX_OUT = (TAG_WIDTH + 1)'(MAX_OUTSTANDING);

  logic [NTAGS-1:0]     busy_q, busy_d;
  logic [TAG_WIDTH:0]   out_q, out_d;
  logic                 err_q, err_d;

  logic [TAG_WIDTH-1:0] free_idx;
  logic                 free_found;
  logic                 any_free;
  logic                 rd_ok;
  logic                 alloc;
  logic                 rel_hit;
  logic                 rel_bad;

  // Free-tag search looks only at registered state, so a tag released this
  // cycle is not visible until the next one.
  pavana_prio_enc #(
    .W  (NTAGS),
    .IW (TAG_WIDTH)
  ) u_prio_enc (
    .vec_i   (busy_q),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  // Issue gate and request handshake; writes bypass the tag pool entirely.
  always_comb begin
    any_free   = free_found && (out_q < MAX_OUT);
    rd_ok      = any_free && !seq_full_i;
    s_reqtid_o = any_free ? free_idx : '0;
    s_req_o    = m_req_i && ((m_cmd_i == CMD_WR) || rd_ok);
    m_ack_o    = s_req_o && s_ack_i;
    alloc      = m_ack_o && (m_cmd_i == CMD_RD);
    tag_wr_o   = alloc;
    rel_hit    = s_resp_i && busy_q[s_resptid_i];
    rel_bad    = s_resp_i && !busy_q[s_resptid_i];
  end

  // Next-state for bitmap, counter and sticky error. An allocated tag is
  // always free and a released tag always busy, so both bit updates can be
  // applied in the same cycle without conflict.
  always_comb begin
    busy_d = busy_q;
    out_d  = out_q;
    err_d  = err_q || rel_bad;
    if (alloc) begin
      busy_d[s_reqtid_o] = 1'b1;
    end
    if (rel_hit) begin
      busy_d[s_resptid_i] = 1'b0;
    end
    case ({alloc, rel_hit})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  // State registers; reset returns every tag to the pool immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      out_q  <= out_d;
      err_q  <= err_d;
    end
  end

  assign outstanding_o = out_q;
  assign busy_o        = |out_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_pavana_tid_alloc.sv
// Self-checking bench for pavana_tid_alloc: directed stimulus with a
// scoreboard of expected issue tags popped whenever tag_wr_o fires.
module tb_pavana_tid_alloc;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       m_req_i, m_cmd_i, s_ack_i, s_resp_i, seq_full_i;
  logic [1:0] s_resptid_i;
  logic       m_ack_o, s_req_o, tag_wr_o, busy_o, err_o;
  logic [1:0] s_reqtid_o;
  logic [2:0] outstanding_o;

  int n_cmp = 0;
  int n_err = 0;
  int wr_pulses = 0;
  logic [1:0] sb_q[$];

  always #5 clk = ~clk;

  pavana_tid_alloc #(
    .TAG_WIDTH       (2),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .m_req_i       (m_req_i),
    .m_cmd_i       (m_cmd_i),
    .m_ack_o       (m_ack_o),
    .s_req_o       (s_req_o),
    .s_ack_i       (s_ack_i),
    .s_reqtid_o    (s_reqtid_o),
    .s_resp_i      (s_resp_i),
    .s_resptid_i   (s_resptid_i),
    .seq_full_i    (seq_full_i),
    .tag_wr_o      (tag_wr_o),
    .outstanding_o (outstanding_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic cmd, input logic ack,
                       input logic resp, input logic [1:0] rtid, input logic sfull);
    m_req_i     = req;
    m_cmd_i     = cmd;
    s_ack_i     = ack;
    s_resp_i    = resp;
    s_resptid_i = rtid;
    seq_full_i  = sfull;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every tag push must match a queued expectation.
  always @(negedge clk) begin
    if (rst_i && tag_wr_o) begin
      wr_pulses++;
      if (sb_q.size() == 0) check_eq("tag_wr_unexpected", 1, 0);
      else                  check_eq("issue_tid", 32'(s_reqtid_o), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_sreq", s_req_o, 0);
    check_eq("rst_mack", m_ack_o, 0);
    check_eq("rst_tagwr", tag_wr_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_out", outstanding_o, 0);
    check_eq("rst_tid", s_reqtid_o, 0);
    check_eq("rst_err", err_o, 0);
    tick();
    rst_i = 1'b1;

    // Fill the pool with four reads
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 0, 0, 0);
      sb_q.push_back(2'(i));
      @(negedge clk);
      check_eq("fill_sreq", s_req_o, 1);
      check_eq("fill_mack", m_ack_o, 1);
      tick();
    end
    check_eq("full_out", outstanding_o, 4);
    check_eq("full_busy", busy_o, 1);
    check_eq("full_wr_pulses", wr_pulses, 4);

    // Fifth read stalls
    drive(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    check_eq("stall_sreq", s_req_o, 0);
    check_eq("stall_mack", m_ack_o, 0);
    check_eq("stall_tid", s_reqtid_o, 0);
    tick();

    // Release tid 2 while the read is held: no same-cycle bypass
    drive(1, 0, 1, 1, 2, 0);
    @(negedge clk);
    check_eq("rel2_nobypass", s_req_o, 0);
    check_eq("rel2_out", outstanding_o, 4);
    tick();
    drive(1, 0, 1, 0, 0, 0);
    sb_q.push_back(2'd2);
    @(negedge clk);
    check_eq("reissue_sreq", s_req_o, 1);
    check_eq("reissue_out_before", outstanding_o, 3);
    tick();
    check_eq("reissue_out_after", outstanding_o, 4);

    // Free tid 1, then allocate it in the same cycle as releasing tid 3
    drive(0, 0, 0, 1, 1, 0);
    tick();
    check_eq("rel1_out", outstanding_o, 3);
    drive(1, 0, 1, 1, 3, 0);
    sb_q.push_back(2'd1);
    @(negedge clk);
    check_eq("both_mack", m_ack_o, 1);
    tick();
    check_eq("both_out", outstanding_o, 3);
    drive(1, 0, 1, 0, 0, 0);
    sb_q.push_back(2'd3);
    @(negedge clk);
    check_eq("after_both_tid", s_reqtid_o, 3);
    tick();
    check_eq("refull_out", outstanding_o, 4);

    // Writes while full and sequencer full
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 0, 0, 1);
      @(negedge clk);
      check_eq("wr_sreq", s_req_o, 1);
      check_eq("wr_mack", m_ack_o, 1);
      check_eq("wr_tagwr", tag_wr_o, 0);
      tick();
    end
    drive(1, 0, 1, 0, 0, 1);
    @(negedge clk);
    check_eq("wr_rd_stall", s_req_o, 0);
    tick();
    drive(1, 1, 0, 0, 0, 1);
    @(negedge clk);
    check_eq("wr_noack_sreq", s_req_o, 1);
    check_eq("wr_noack_mack", m_ack_o, 0);
    tick();
    check_eq("wr_out", outstanding_o, 4);

    // Free tids 0 and 2, then stall on seq_full with free tags
    drive(0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 1, 2, 0);
    tick();
    check_eq("two_free_out", outstanding_o, 2);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 0, 0, 1);
      @(negedge clk);
      check_eq("sfull_sreq", s_req_o, 0);
      check_eq("sfull_tid", s_reqtid_o, 0);
      tick();
    end
    drive(1, 0, 1, 0, 0, 0);
    sb_q.push_back(2'd0);
    @(negedge clk);
    check_eq("sfull_release_sreq", s_req_o, 1);
    tick();
    check_eq("sfull_out", outstanding_o, 3);

    // Free tid 0, then respond on it again: bad response
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check_eq("rel0_out", outstanding_o, 2);
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check_eq("bad_err_pre", err_o, 0);
    tick();
    check_eq("bad_err", err_o, 1);
    check_eq("bad_out", outstanding_o, 2);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check_eq("err_sticky", err_o, 1);
    drive(0, 0, 0, 1, 1, 0);
    tick();
    check_eq("rel_after_err_out", outstanding_o, 1);
    check_eq("rel_after_err_err", err_o, 1);

    // Asynchronous reset mid-cycle
    drive(0, 0, 0, 0, 0, 0);
    #1 rst_i = 1'b0;
    #1;
    check_eq("arst_out", outstanding_o, 0);
    check_eq("arst_busy", busy_o, 0);
    check_eq("arst_err", err_o, 0);
    check_eq("arst_sreq", s_req_o, 0);
    check_eq("arst_tagwr", tag_wr_o, 0);
    check_eq("arst_tid", s_reqtid_o, 0);
    tick();
    rst_i = 1'b1;

    // Response for a pre-reset tag is now an error
    drive(0, 0, 0, 1, 3, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check_eq("stale_err", err_o, 1);
    check_eq("stale_out", outstanding_o, 0);

    check_eq("sb_drained", sb_q.size(), 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pavana_tid_alloc.md
Name: pavana_tid_alloc

Overview:
- Per-slave read-transaction-ID allocator and issue gate.
- Sits between the crossbar's slave-side request port and an out-of-order slave.
- Hands out a free tag on every accepted read and stalls reads when no tag is free or the response sequencer's tag FIFO is full.
- Returns tags to the pool when the slave responds, so no two outstanding reads share a TID.

Parameters:
- TAG_WIDTH, 2, tag width; pool size NTAGS = 2**TAG_WIDTH.
- MAX_OUTSTANDING, 4, cap on concurrently outstanding reads; legal range 1..NTAGS.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- m_req_i  in  1  request from crossbar slave port.
- m_cmd_i  in  1  0 = read, 1 = write.
- m_ack_o  out  1  acknowledge back to crossbar.
- s_req_o  out  1  request to slave.
- s_ack_i  in  1  slave accepts request.
- s_reqtid_o  out  TAG_WIDTH  tag attached to the current request.
- s_resp_i  in  1  slave read response valid.
- s_resptid_i  in  TAG_WIDTH  tag of the response.
- seq_full_i  in  1  response sequencer tag FIFO full.
- tag_wr_o  out  1  push s_reqtid_o into the sequencer tag FIFO.
- outstanding_o  out  TAG_WIDTH+1  number of busy tags.
- busy_o  out  1  outstanding_o != 0.
- err_o  out  1  sticky protocol error.

Behaviour:
- State:
  - busy bitmap busy_q[NTAGS-1:0].
  - counter out_q (TAG_WIDTH+1 bits).
  - sticky err_q.
- Reset (rst_i=0, asynchronous): busy_q=0, out_q=0, err_q=0. Consequences:
  - s_req_o=0 and m_ack_o=0 whenever m_req_i=0.
  - tag_wr_o=0.
  - busy_o=0, outstanding_o=0.
  - s_reqtid_o=0.
- Free tag selection: lowest index i with busy_q[i]=0. Computed combinationally from registered state only.
  - any_free = (busy_q != all-ones) and (out_q < MAX_OUTSTANDING).
  - s_reqtid_o = selected index; 0 when none is free.
- Read gate: rd_ok = any_free & !seq_full_i.
- Request path:
  - s_req_o = m_req_i & (m_cmd_i | rd_ok).
  - m_ack_o = s_req_o & s_ack_i.
  - Writes are never stalled and consume no tag.
- Allocation: on m_ack_o & !m_cmd_i:
  - tag_wr_o=1 in the same cycle.
  - busy_q[s_reqtid_o] is set on the next clock edge.
  - out_q is incremented on the next clock edge.
- Release: on s_resp_i with busy_q[s_resptid_i]=1:
  - busy_q[s_resptid_i] is cleared on the next clock edge.
  - out_q is decremented on the next clock edge.
  - A freed tag is usable from the following cycle; there is no same-cycle bypass.
- Simultaneous allocate and release in one cycle:
  - Both bitmap updates apply; out_q is unchanged.
  - The two tags are always distinct, because an allocated tag is free and a released tag is busy.
- Bad response: s_resp_i on a tag with busy_q=0 sets err_q=1. The bitmap and counter are unchanged. Only reset clears err_q.
- Combinational path: m_req_i/m_cmd_i -> s_req_o has zero cycles of latency. No other input has a combinational path to s_reqtid_o.
- Full pool: with out_q = MAX_OUTSTANDING, reads hold s_req_o=0 until a release is registered. The request is held by the master; no request is dropped.
- Reset mid-operation: all tags are returned to the pool immediately. Responses for pre-reset tags then flag err_o.

Decomposition:
- pavana_xbar_pkg holds:
  - localparam default TAG_WIDTH.
  - CMD_RD=0 and CMD_WR=1 constants.
  - a function computing NTAGS.
- One sub-module, pavana_prio_enc: parameterised lowest-zero-bit finder returning index and found flag. Instantiated once.

Test Plan:
- Reset, then 4 reads to tags with s_ack_i=1, no responses -> s_reqtid_o issued 0,1,2,3; tag_wr_o pulses 4 times; outstanding_o=4; 5th read holds s_req_o=0 while m_ack_o=0.
- From full pool, s_resp_i with tid 2 -> next cycle the stalled read issues with s_reqtid_o=2; outstanding_o=4 again.
- Same cycle: read accepted on tag 1 and response on tid 3 (busy) -> busy_q bit1 set, bit3 cleared, outstanding_o unchanged.
- Writes interleaved while pool full and seq_full_i=1 -> writes acked, tag_wr_o=0, outstanding_o unchanged.
- seq_full_i=1 with free tags -> reads stall; deassert -> read issues the next cycle with the lowest free tag.
- Response on a free tid 0 -> err_o=1 and stays 1; async rst_i low mid-cycle -> all outputs return to reset values immediately.
